// File: rtl/vga_sync_gen.sv
// Raster timing generator for VGA (640x480 @ 60 Hz by default).
// Free-running x/y counters with sync and blank decoded from the next-state counters.
module vga_sync_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  output logic       HS,
  output logic       VS,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       blank
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync window ending exactly at 1024 still fits
  localparam logic [10:0] H_VIS_W  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_W  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_q, blank_d;
  logic [10:0] x_w, y_w;

  // Next-state counters and the sync/blank decode of that next state
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = 10'd0;
      if (y_q == V_LAST) begin
        y_d = 10'd0;
      end else begin
        y_d = y_q + 10'd1;
      end
    end else begin
      x_d = x_q + 10'd1;
      y_d = y_q;
    end

    x_w     = {1'b0, x_d};
    y_w     = {1'b0, y_d};
    hs_d    = ((x_w >= HS_START) && (x_w < HS_END)) ? HS_POL : ~HS_POL;
    vs_d    = ((y_w >= VS_START) && (y_w < VS_END)) ? VS_POL : ~VS_POL;
    blank_d = (x_w >= H_VIS_W) || (y_w >= V_VIS_W);
  end

  // Output registers; reset parks the raster on visible pixel (0,0)
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign HS    = hs_q;
  assign VS    = vs_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance for line/reset behaviour and a
// small-raster, positive-polarity instance for whole-frame behaviour.
module tb_vga_sync_gen;

  typedef struct {
    int   k;
    int   ex;
    int   ey;
    logic hs;
    logic vs;
    logic blank;
  } vec_t;

  logic       clk;
  logic       rst_a, rst_b;
  logic       hs_a, vs_a, blank_a, hs_b, vs_b, blank_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       chk_en;
  int         checks;
  int         failures;

  vga_sync_gen dut_a (
    .CLK(clk), .RST(rst_a), .HS(hs_a), .VS(vs_a), .x(x_a), .y(y_a), .blank(blank_a)
  );

  // Small raster: H 8/2/3/2 (total 15), V 6/1/2/2 (total 11), active-high syncs
  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_b (
    .CLK(clk), .RST(rst_b), .HS(hs_b), .VS(vs_b), .x(x_b), .y(y_b), .blank(blank_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model(input int xv, input int yv,
                                       input int hv, input int hf, input int hsy,
                                       input int vv, input int vf, input int vsy,
                                       input logic hpol, input logic vpol);
    logic h, v, b;
    h = ((xv >= hv + hf) && (xv < hv + hf + hsy)) ? hpol : ~hpol;
    v = ((yv >= vv + vf) && (yv < vv + vf + vsy)) ? vpol : ~vpol;
    b = (xv >= hv) || (yv >= vv);
    return {h, v, b};
  endfunction

  // Every-cycle alignment check of HS/VS/blank against the displayed (x,y)
  always @(negedge clk) begin
    if (chk_en) begin
      check("align_a", int'({hs_a, vs_a, blank_a}),
            int'(model(int'(x_a), int'(y_a), 640, 16, 96, 480, 10, 2, 1'b0, 1'b0)));
      check("align_b", int'({hs_b, vs_b, blank_b}),
            int'(model(int'(x_b), int'(y_b), 8, 2, 3, 6, 1, 2, 1'b1, 1'b1)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_a(input vec_t v);
    check($sformatf("a_x@%0d", v.k), int'(x_a), v.ex);
    check($sformatf("a_y@%0d", v.k), int'(y_a), v.ey);
    check($sformatf("a_flags@%0d", v.k), int'({hs_a, vs_a, blank_a}),
          int'({v.hs, v.vs, v.blank}));
  endtask

  task automatic cmp_b(input vec_t v);
    check($sformatf("b_x@%0d", v.k), int'(x_b), v.ex);
    check($sformatf("b_y@%0d", v.k), int'(y_b), v.ey);
    check($sformatf("b_flags@%0d", v.k), int'({hs_b, vs_b, blank_b}),
          int'({v.hs, v.vs, v.blank}));
  endtask

  vec_t va[12];
  vec_t vb[11];

  initial begin
    int cur;
    int idx;
    int hs_low;
    int blank_cnt;
    int hs_act;
    int vs_act;

    // k = clocks since the last clock that sampled RST high
    va[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b0};
    va[1]  = '{1,    1,   0, 1'b1, 1'b1, 1'b0};
    va[2]  = '{639,  639, 0, 1'b1, 1'b1, 1'b0};
    va[3]  = '{640,  640, 0, 1'b1, 1'b1, 1'b1};
    va[4]  = '{655,  655, 0, 1'b1, 1'b1, 1'b1};
    va[5]  = '{656,  656, 0, 1'b0, 1'b1, 1'b1};
    va[6]  = '{751,  751, 0, 1'b0, 1'b1, 1'b1};
    va[7]  = '{752,  752, 0, 1'b1, 1'b1, 1'b1};
    va[8]  = '{799,  799, 0, 1'b1, 1'b1, 1'b1};
    va[9]  = '{800,  0,   1, 1'b1, 1'b1, 1'b0};
    va[10] = '{1456, 656, 1, 1'b0, 1'b1, 1'b1};
    va[11] = '{1900, 300, 2, 1'b1, 1'b1, 1'b0};

    vb[0]  = '{0,   0,  0,  1'b0, 1'b0, 1'b0};
    vb[1]  = '{10,  10, 0,  1'b1, 1'b0, 1'b1};
    vb[2]  = '{13,  13, 0,  1'b0, 1'b0, 1'b1};
    vb[3]  = '{82,  7,  5,  1'b0, 1'b0, 1'b0};
    vb[4]  = '{83,  8,  5,  1'b0, 1'b0, 1'b1};
    vb[5]  = '{90,  0,  6,  1'b0, 1'b0, 1'b1};
    vb[6]  = '{105, 0,  7,  1'b0, 1'b1, 1'b1};
    vb[7]  = '{145, 10, 9,  1'b1, 1'b0, 1'b1};
    vb[8]  = '{164, 14, 10, 1'b0, 1'b0, 1'b1};
    vb[9]  = '{165, 0,  0,  1'b0, 1'b0, 1'b0};
    vb[10] = '{330, 0,  0,  1'b0, 1'b0, 1'b0};

    checks = 0;
    failures = 0;
    chk_en = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Phase 1: default timing, one line and a bit, then reset mid-line
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst_a = 1'b0;
    cur = 0;
    hs_low = 0;
    blank_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      while (cur < va[i].k) begin
        if (cur < 800) begin
          hs_low    += (hs_a == 1'b0) ? 1 : 0;
          blank_cnt += (blank_a == 1'b1) ? 1 : 0;
        end
        tick();
        cur++;
      end
      cmp_a(va[i]);
    end
    check("a_hs_low_clocks_line0", hs_low, 96);
    check("a_blank_clocks_line0", blank_cnt, 160);

    rst_a = 1'b1;
    tick();
    check("a_rst_x", int'(x_a), 0);
    check("a_rst_y", int'(y_a), 0);
    check("a_rst_flags", int'({hs_a, vs_a, blank_a}), 6);
    tick();
    tick();
    check("a_rst_hold_x", int'(x_a), 0);
    rst_a = 1'b0;
    tick();
    check("a_release_x", int'(x_a), 1);
    check("a_release_y", int'(y_a), 0);

    // Phase 2: small raster, two full frames
    rst_b = 1'b0;
    idx = 0;
    hs_act = 0;
    vs_act = 0;
    for (int k = 0; k <= 330; k++) begin
      if (k > 0) tick();
      if (k < 330) begin
        hs_act += (hs_b == 1'b1) ? 1 : 0;
        vs_act += (vs_b == 1'b1) ? 1 : 0;
      end
      if ((idx < 11) && (vb[idx].k == k)) begin
        cmp_b(vb[idx]);
        idx++;
      end
    end
    check("b_vectors_hit", idx, 11);
    check("b_hs_active_clocks_2frames", hs_act, 66);
    check("b_vs_active_clocks_2frames", vs_act, 60);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
